// File: rtl/ksk_mgr_cut_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ksk_mgr_cut_sched_pkg
// Description : Shared definitions for the KSK cut read scheduler: cut and
//               slot index widths, the scheduler FSM state encoding and the
//               "column complete" mask constant.
// Revision    : 1.0 - initial release
// ============================================================================
package ksk_mgr_cut_sched_pkg;

  // Number of cuts per column; mirrors the common cut definition of the
  // KSK manager.
  localparam int KSK_CUT_NB   = 16;
  localparam int KSK_CUT_W    = $clog2(KSK_CUT_NB);

  // Default ring depth and its index width. Parameterised instances derive
  // their own index width from their SLOT_NB.
  localparam int SLOT_NB_DFLT = 4;
  localparam int SLOT_W       = $clog2(SLOT_NB_DFLT);

  // A slot holds a complete column once every cut bit is set.
  localparam logic [KSK_CUT_NB-1:0] CUT_FULL = '1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FULL = 2'd1,
    ST_READ      = 2'd2
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/ksk_mgr_slot_mask.sv
`default_nettype none
// ============================================================================
// Module      : ksk_mgr_slot_mask
// Description : Per-slot record of which cuts the loader has written.
//               A set request marks one cut of one slot; a clear request wipes
//               a whole slot when it is released. Writing an already-written
//               cut, or writing into the slot being released in the same
//               cycle, raises a sticky double-load error.
// Ports       : clk, a_rst         clock, async active-high reset
//               set_vld/slot/cut   loader cut-written event
//               clr_vld/slot       slot release
//               err_clr            clears err_double_load
//               full               per-slot "all cuts present" vector
//               err_double_load    sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module ksk_mgr_slot_mask
  import ksk_mgr_cut_sched_pkg::*;
#(
  parameter  int SLOT_NB    = SLOT_NB_DFLT,
  localparam int SLOT_IDX_W = $clog2(SLOT_NB)
) (
  input  logic                  clk,
  input  logic                  a_rst,
  input  logic                  set_vld,
  input  logic [SLOT_IDX_W-1:0] set_slot,
  input  logic [KSK_CUT_W-1:0]  set_cut,
  input  logic                  clr_vld,
  input  logic [SLOT_IDX_W-1:0] clr_slot,
  input  logic                  err_clr,
  output logic [SLOT_NB-1:0]    full,
  output logic                  err_double_load
);

  logic [SLOT_NB-1:0] w_dup_hit;
  logic               w_clr_collide;
  logic               w_err_set;

  for (genvar g = 0; g < SLOT_NB; g++) begin : g_slot
    logic [KSK_CUT_NB-1:0] r_mask;
    logic                  w_set_here;
    logic                  w_clr_here;

    assign w_set_here   = set_vld && (set_slot == SLOT_IDX_W'(g));
    assign w_clr_here   = clr_vld && (clr_slot == SLOT_IDX_W'(g));
    assign w_dup_hit[g] = w_set_here && r_mask[set_cut];

    // Release has priority: a load racing the release is discarded so the
    // slot starts its next fill from an empty mask.
    always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
        r_mask <= '0;
      end else if (w_clr_here) begin
        r_mask <= '0;
      end else if (w_set_here) begin
        r_mask[set_cut] <= 1'b1;
      end
    end

    assign full[g] = (r_mask == CUT_FULL);
  end

  assign w_clr_collide = set_vld && clr_vld && (set_slot == clr_slot);
  assign w_err_set     = (|w_dup_hit) || w_clr_collide;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      err_double_load <= 1'b0;
    end else if (w_err_set) begin
      err_double_load <= 1'b1;
    end else if (err_clr) begin
      err_double_load <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ksk_mgr_cut_rd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ksk_mgr_cut_rd_scheduler
// Description : Sequences reads of key-switch-key columns out of a ring of
//               SLOT_NB slots, each split into KSK_CUT_NB cuts. For each column
//               of a batch command it waits for the current slot to be fully
//               loaded, issues one read beat per cut, then releases the slot
//               back to the loader and advances the ring pointer.
// Ports       : clk, a_rst                  clock, async active-high reset
//               cmd_vld/rdy, cmd_iter_nb    batch command (column count)
//               ld_vld/slot/cut             loader cut-written event
//               rd_vld/rdy/slot/cut/last    read request to datapath
//               slot_free_vld/id            slot release pulse to loader
//               done, busy                  command status
//               err_double_load, err_clr    sticky load protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module ksk_mgr_cut_rd_scheduler
  import ksk_mgr_cut_sched_pkg::*;
#(
  parameter  int SLOT_NB    = SLOT_NB_DFLT,
  parameter  int CMD_ITER_W = 8,
  localparam int SLOT_IDX_W = $clog2(SLOT_NB)
) (
  input  logic                  clk,
  input  logic                  a_rst,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [CMD_ITER_W-1:0] cmd_iter_nb,
  input  logic                  ld_vld,
  input  logic [SLOT_IDX_W-1:0] ld_slot,
  input  logic [KSK_CUT_W-1:0]  ld_cut,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output logic [SLOT_IDX_W-1:0] rd_slot,
  output logic [KSK_CUT_W-1:0]  rd_cut,
  output logic                  rd_last,
  output logic                  slot_free_vld,
  output logic [SLOT_IDX_W-1:0] slot_free_id,
  output logic                  done,
  output logic                  busy,
  output logic                  err_double_load,
  input  logic                  err_clr
);

  sched_state_e          r_state;
  logic [SLOT_IDX_W-1:0] r_slot_ptr;
  logic [CMD_ITER_W-1:0] r_iter_nb;
  logic [CMD_ITER_W-1:0] r_iter_cnt;

  logic [SLOT_NB-1:0]    w_full;
  logic                  w_release;
  logic [CMD_ITER_W-1:0] w_iter_next;

  // The last beat of a column being accepted releases its slot this edge.
  assign w_release   = (r_state == ST_READ) && rd_rdy && rd_last;
  assign w_iter_next = r_iter_cnt + 1'b1;
  assign busy        = (r_state != ST_IDLE);

  ksk_mgr_slot_mask #(
    .SLOT_NB (SLOT_NB)
  ) u_slot_mask (
    .clk             (clk),
    .a_rst           (a_rst),
    .set_vld         (ld_vld),
    .set_slot        (ld_slot),
    .set_cut         (ld_cut),
    .clr_vld         (w_release),
    .clr_slot        (rd_slot),
    .err_clr         (err_clr),
    .full            (w_full),
    .err_double_load (err_double_load)
  );

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_state       <= ST_IDLE;
      r_slot_ptr    <= '0;
      r_iter_nb     <= '0;
      r_iter_cnt    <= '0;
      cmd_rdy       <= 1'b0;
      rd_vld        <= 1'b0;
      rd_slot       <= '0;
      rd_cut        <= '0;
      rd_last       <= 1'b0;
      slot_free_vld <= 1'b0;
      slot_free_id  <= '0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      slot_free_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          cmd_rdy <= 1'b1;
          if (cmd_vld && cmd_rdy) begin
            r_iter_nb  <= cmd_iter_nb;
            r_iter_cnt <= '0;
            if (cmd_iter_nb == '0) begin
              done <= 1'b1;
            end else begin
              r_state <= ST_WAIT_FULL;
              cmd_rdy <= 1'b0;
            end
          end
        end

        ST_WAIT_FULL: begin
          if (w_full[r_slot_ptr]) begin
            r_state <= ST_READ;
            rd_vld  <= 1'b1;
            rd_slot <= r_slot_ptr;
            rd_cut  <= '0;
            rd_last <= (KSK_CUT_NB == 1);
          end
        end

        ST_READ: begin
          if (rd_rdy) begin
            if (rd_last) begin
              rd_vld        <= 1'b0;
              rd_cut        <= '0;
              rd_last       <= 1'b0;
              slot_free_vld <= 1'b1;
              slot_free_id  <= r_slot_ptr;
              // Ring depth is a power of two, so the increment wraps itself.
              r_slot_ptr    <= r_slot_ptr + 1'b1;
              r_iter_cnt    <= w_iter_next;
              if (w_iter_next == r_iter_nb) begin
                r_state <= ST_IDLE;
                done    <= 1'b1;
                cmd_rdy <= 1'b1;
              end else begin
                r_state <= ST_WAIT_FULL;
              end
            end else begin
              rd_cut  <= rd_cut + 1'b1;
              rd_last <= (rd_cut == KSK_CUT_W'(KSK_CUT_NB - 2));
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ksk_mgr_cut_rd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ksk_mgr_cut_rd_scheduler
// Description : Directed-random bench for the KSK cut read scheduler. A small
//               model tracks which cuts of which slot are loaded, the ring
//               pointer and the error flag; accepted read beats, slot releases
//               and done pulses are captured and compared with the column
//               order the model predicts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ksk_mgr_cut_rd_scheduler;

  localparam int SLOTS = 4;
  localparam int CUTS  = 16;

  logic       clk = 1'b0;
  logic       a_rst = 1'b1;
  logic       cmd_vld = 1'b0;
  logic       cmd_rdy;
  logic [7:0] cmd_iter_nb = 8'd0;
  logic       ld_vld = 1'b0;
  logic [1:0] ld_slot = 2'd0;
  logic [3:0] ld_cut = 4'd0;
  logic       rd_vld;
  logic       rd_rdy = 1'b1;
  logic [1:0] rd_slot;
  logic [3:0] rd_cut;
  logic       rd_last;
  logic       slot_free_vld;
  logic [1:0] slot_free_id;
  logic       done;
  logic       busy;
  logic       err_double_load;
  logic       err_clr = 1'b0;

  always #5 clk = ~clk;

  ksk_mgr_cut_rd_scheduler #(
    .SLOT_NB    (SLOTS),
    .CMD_ITER_W (8)
  ) dut (
    .clk             (clk),
    .a_rst           (a_rst),
    .cmd_vld         (cmd_vld),
    .cmd_rdy         (cmd_rdy),
    .cmd_iter_nb     (cmd_iter_nb),
    .ld_vld          (ld_vld),
    .ld_slot         (ld_slot),
    .ld_cut          (ld_cut),
    .rd_vld          (rd_vld),
    .rd_rdy          (rd_rdy),
    .rd_slot         (rd_slot),
    .rd_cut          (rd_cut),
    .rd_last         (rd_last),
    .slot_free_vld   (slot_free_vld),
    .slot_free_id    (slot_free_id),
    .done            (done),
    .busy            (busy),
    .err_double_load (err_double_load),
    .err_clr         (err_clr)
  );

  // ---------------- capture of DUT activity (sampled mid-cycle) -----------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int beat_cyc_q[$];
  int beat_slot_q[$];
  int beat_cut_q[$];
  int beat_last_q[$];
  int free_q[$];
  int free_cyc_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int stall_viol = 0;

  logic       p_vld = 1'b0;
  logic       p_rdy = 1'b0;
  logic [1:0] p_slot = 2'd0;
  logic [3:0] p_cut = 4'd0;
  logic       p_last = 1'b0;

  always @(negedge clk) begin
    if (rd_vld && rd_rdy) begin
      beat_cyc_q.push_back(cyc);
      beat_slot_q.push_back(int'(rd_slot));
      beat_cut_q.push_back(int'(rd_cut));
      beat_last_q.push_back(int'(rd_last));
    end
    if (slot_free_vld) begin
      free_q.push_back(int'(slot_free_id));
      free_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    // A stalled request must be held unchanged into the next cycle.
    if (p_vld && !p_rdy && !a_rst) begin
      if (!(rd_vld && rd_slot == p_slot && rd_cut == p_cut && rd_last == p_last))
        stall_viol <= stall_viol + 1;
    end
    p_vld  <= rd_vld;
    p_rdy  <= rd_rdy;
    p_slot <= rd_slot;
    p_cut  <= rd_cut;
    p_last <= rd_last;
  end

  // ---------------- reference model ---------------------------------------
  bit m_mask[SLOTS][CUTS];
  bit m_err = 1'b0;
  int m_ptr = 0;
  int seen_free = 0;
  bit bp_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int beat_base = 0;
  int free_base = 0;
  int done_base = 0;
  int t_hs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) rd_rdy = ($urandom_range(0, 1) == 1);
    while (seen_free < free_q.size()) begin
      for (int c = 0; c < CUTS; c++) m_mask[free_q[seen_free]][c] = 1'b0;
      seen_free++;
    end
  endtask

  task automatic load(input int s, input int c);
    ld_vld  = 1'b1;
    ld_slot = 2'(s);
    ld_cut  = 4'(c);
    if (m_mask[s][c]) m_err = 1'b1;
    m_mask[s][c] = 1'b1;
    tick();
    ld_vld = 1'b0;
  endtask

  // Load every cut of a slot except 'skip' (-1 loads all) in random order.
  task automatic load_slot_shuffled(input int s, input int skip);
    int perm[CUTS];
    int j;
    int t;
    for (int i = 0; i < CUTS; i++) perm[i] = i;
    for (int i = CUTS - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < CUTS; i++)
      if (perm[i] != skip) load(s, perm[i]);
  endtask

  task automatic issue(input int n);
    for (int k = 0; k < 100 && !cmd_rdy; k++) tick();
    check("cmd_rdy_before_issue", 32'(cmd_rdy), 32'd1);
    beat_base   = beat_cyc_q.size();
    free_base   = free_q.size();
    done_base   = done_cnt;
    cmd_vld     = 1'b1;
    cmd_iter_nb = 8'(n);
    t_hs        = cyc;
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int k = 0; k < budget && done_cnt == done_base; k++) tick();
    check({tag, "_done_pulse"}, 32'(done_cnt - done_base), 32'd1);
  endtask

  // Columns are read from consecutive ring slots starting at the model
  // pointer, 16 beats each in cut order, last flagged on cut 15.
  task automatic verify(input string tag, input int n);
    int bad;
    int idx;
    bad = 0;
    check({tag, "_beat_count"}, 32'(beat_cyc_q.size() - beat_base), 32'(n * CUTS));
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < CUTS; c++) begin
        idx = beat_base + k * CUTS + c;
        if (idx < beat_cyc_q.size()) begin
          if (beat_slot_q[idx] != (m_ptr + k) % SLOTS || beat_cut_q[idx] != c ||
              beat_last_q[idx] != int'(c == CUTS - 1))
            bad++;
        end
      end
    end
    check({tag, "_beat_seq_errs"}, 32'(bad), 32'd0);
    check({tag, "_free_count"}, 32'(free_q.size() - free_base), 32'(n));
    bad = 0;
    for (int k = 0; k < n; k++)
      if (free_base + k < free_q.size() && free_q[free_base + k] != (m_ptr + k) % SLOTS) bad++;
    check({tag, "_free_order_errs"}, 32'(bad), 32'd0);
    m_ptr = (m_ptr + n) % SLOTS;
  endtask

  initial begin
    int refills;
    int n_cyc;
    int last_idx;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_rd_vld", 32'(rd_vld), 32'd0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_double_load), 32'd0);
    check("rst_free", 32'(slot_free_vld), 32'd0);
    a_rst = 1'b0;
    tick();
    check("cmd_rdy_after_rst", 32'(cmd_rdy), 32'd1);

    // ---- single column, cuts loaded in reverse order ----
    for (int c = CUTS - 1; c >= 0; c--) load(0, c);
    issue(1);
    wait_done("t1", 200);
    last_idx = beat_cyc_q.size() - 1;
    check("t1_first_beat_cyc", 32'(beat_cyc_q[beat_base]), 32'(t_hs + 2));
    check("t1_burst_span", 32'(beat_cyc_q[last_idx] - beat_cyc_q[beat_base]), 32'(CUTS - 1));
    check("t1_free_cyc", 32'(free_cyc_q[free_q.size() - 1]), 32'(beat_cyc_q[last_idx] + 1));
    check("t1_done_cyc", 32'(done_cyc), 32'(beat_cyc_q[last_idx] + 1));
    verify("t1", 1);

    // ---- zero-length command ----
    beat_base   = beat_cyc_q.size();
    cmd_vld     = 1'b1;
    cmd_iter_nb = 8'd0;
    tick();
    cmd_vld = 1'b0;
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_cmd_rdy", 32'(cmd_rdy), 32'd1);
    repeat (5) tick();
    check("t2_no_beats", 32'(beat_cyc_q.size() - beat_base), 32'd0);

    // ---- six columns over a four-slot ring, loader refills freed slots ----
    for (int k = 0; k < SLOTS; k++) load_slot_shuffled((m_ptr + k) % SLOTS, -1);
    issue(6);
    refills = 0;
    for (int k = 0; k < 3000 && done_cnt == done_base; k++) begin
      tick();
      if (refills < 2 && free_q.size() > free_base + refills) begin
        load_slot_shuffled(free_q[free_base + refills], -1);
        refills++;
      end
    end
    check("t3_done_pulse", 32'(done_cnt - done_base), 32'd1);
    verify("t3", 6);

    // ---- wait for the missing cut ----
    load_slot_shuffled(m_ptr, 7);
    issue(1);
    repeat (10) tick();
    check("t4_wait_rd_vld", 32'(rd_vld), 32'd0);
    check("t4_wait_busy", 32'(busy), 32'd1);
    n_cyc = cyc;
    load(m_ptr, 7);
    wait_done("t4", 200);
    check("t4_first_beat_cyc", 32'(beat_cyc_q[beat_base]), 32'(n_cyc + 2));
    verify("t4", 1);

    // ---- random backpressure ----
    for (int k = 0; k < 3; k++) load_slot_shuffled((m_ptr + k) % SLOTS, -1);
    bp_en = 1'b1;
    issue(3);
    wait_done("t5", 3000);
    bp_en  = 1'b0;
    rd_rdy = 1'b1;
    verify("t5", 3);
    check("t5_stall_stable_errs", 32'(stall_viol), 32'd0);

    // ---- double load and error clear ----
    load(1, 3);
    check("t6_err_single", 32'(err_double_load), 32'(m_err));
    load(1, 3);
    check("t6_err_double", 32'(err_double_load), 32'(m_err));
    repeat (3) tick();
    check("t6_err_sticky", 32'(err_double_load), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err   = 1'b0;
    check("t6_err_cleared", 32'(err_double_load), 32'(m_err));
    err_clr = 1'b1;
    load(1, 3);
    err_clr = 1'b0;
    check("t6_err_wins_over_clr", 32'(err_double_load), 32'(m_err));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err   = 1'b0;
    check("t6_err_cleared2", 32'(err_double_load), 32'(m_err));

    // ---- asynchronous reset in the middle of a read ----
    load_slot_shuffled(m_ptr, -1);
    rd_rdy = 1'b0;
    issue(2);
    for (int k = 0; k < 50 && !rd_vld; k++) tick();
    check("t7_in_read", 32'(rd_vld), 32'd1);
    tick();
    #3;
    a_rst = 1'b1;
    #1;
    check("t7_rst_rd_vld", 32'(rd_vld), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("t7_rst_rd_slot", 32'(rd_slot), 32'd0);
    for (int s = 0; s < SLOTS; s++)
      for (int c = 0; c < CUTS; c++) m_mask[s][c] = 1'b0;
    m_ptr = 0;
    m_err = 1'b0;
    tick();
    tick();
    a_rst  = 1'b0;
    rd_rdy = 1'b1;
    tick();
    check("t7_cmd_rdy_after_rst", 32'(cmd_rdy), 32'd1);
    issue(1);
    repeat (20) tick();
    check("t7_waits_fresh_load", 32'(beat_cyc_q.size() - beat_base), 32'd0);
    check("t7_busy_waiting", 32'(busy), 32'd1);
    load_slot_shuffled(0, -1);
    wait_done("t7", 200);
    verify("t7", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ksk_mgr_cut_rd_scheduler.md
Name: ksk_mgr_cut_rd_scheduler

Overview:
Sequences reads of key-switch-key columns out of the KSK buffer, which is split into KSK_CUT_NB cuts and organised as a ring of SLOT_NB slots.
- Tracks, per slot, which cuts the loader has filled.
- For each column of a batch command, waits until its slot is complete, then issues one read beat per cut.
- Releases the slot back to the loader once all beats are accepted.
- Sits between the KSK loader (write side) and the keyswitch datapath read port.

Parameters:
KSK_CUT_NB, 16, number of cuts per column; taken from ksk_mgr_common_cut_definition_pkg.
SLOT_NB, 4, number of column slots in the ring buffer; power of 2, ≥2.
CMD_ITER_W, 8, width of the per-command column count.

Ports:
clk  in  1  clock.
a_rst  in  1  reset, asynchronous, active-high.
cmd_vld  in  1  batch command valid.
cmd_rdy  out  1  high only in IDLE.
cmd_iter_nb  in  CMD_ITER_W  number of columns to read; 0 is legal.
ld_vld  in  1  loader finished writing one cut of one slot (single-cycle event).
ld_slot  in  $clog2(SLOT_NB)  slot written.
ld_cut  in  $clog2(KSK_CUT_NB)  cut written.
rd_vld  out  1  read request valid (registered).
rd_rdy  in  1  datapath accepts read.
rd_slot  out  $clog2(SLOT_NB)  slot to read.
rd_cut  out  $clog2(KSK_CUT_NB)  cut to read.
rd_last  out  1  high on the beat where rd_cut = KSK_CUT_NB-1.
slot_free_vld  out  1  one-cycle pulse: slot released to loader.
slot_free_id  out  $clog2(SLOT_NB)  released slot.
done  out  1  one-cycle pulse: command complete.
busy  out  1  state ≠ IDLE.
err_double_load  out  1  sticky protocol error.
err_clr  in  1  clears err_double_load.

Behaviour:
- Reset (async, any time including mid-batch):
  - Outputs: all 0, cmd_rdy=1 one cycle after reset release is sampled (IDLE).
  - State: all slot masks cleared, slot pointer 0, cut counter 0, iteration counter 0.
- Slot mask: SLOT_NB × KSK_CUT_NB bits.
  - ld_vld sets bit [ld_slot][ld_cut] at the next edge.
  - Setting an already-set bit: raise err_double_load, bit stays 1.
  - Load to the slot being released in the same cycle: raise err_double_load, load discarded, mask ends all-0.
  - err_clr and a new error in the same cycle: error wins.
- FSM states: IDLE, WAIT_FULL, READ.
  - IDLE: cmd_vld & cmd_rdy at cycle T latches cmd_iter_nb.
    - If 0: stay IDLE, done=1 at T+1.
    - Else: WAIT_FULL at T+1.
  - WAIT_FULL: when mask[slot_ptr] is all-ones, go to READ. rd_vld=1 from the next cycle, earliest T+2. rd_slot=slot_ptr, rd_cut=0.
  - READ: rd_vld held high; rd_slot, rd_cut and rd_last stay stable while rd_rdy=0. Each handshake increments rd_cut on the next edge.
  - Handshake with rd_last=1 at cycle U. At U+1:
    - rd_vld=0, mask[slot_ptr] cleared.
    - slot_free_vld=1 with slot_free_id = old slot_ptr.
    - slot_ptr ← (slot_ptr+1) mod SLOT_NB, wrapping SLOT_NB-1→0.
    - Iteration counter ++.
    - If this was the last iteration: IDLE with done=1. Otherwise: WAIT_FULL.
  - Minimum one idle cycle between columns.
- slot_ptr persists across commands; it is not reset by a new command.
- Loads to any slot are allowed in every state, including IDLE (prefetch). Masks are never cleared except by release or reset.
- Cuts may arrive in any order and interleaved across slots. Completion is order-independent.
- Counter widths: iteration counter CMD_ITER_W bits. Max cmd_iter_nb = 2^CMD_ITER_W−1 with no overflow.

Decomposition:
- Shared package ksk_mgr_cut_sched_pkg:
  - KSK_CUT_W = $clog2(KSK_CUT_NB).
  - SLOT_W.
  - FSM state enum (IDLE, WAIT_FULL, READ).
  - Helper constant CUT_FULL = all-ones KSK_CUT_NB-bit vector.
- Sub-module ksk_mgr_slot_mask:
  - Mask array with set port, clear port and double-load detection.
  - Outputs a per-slot full vector.
- Top level holds the FSM, counters, read outputs and release logic.

Test Plan:
1. Preload slot 0 with all 16 cuts in reverse order, then send cmd_iter_nb=1 with rd_rdy=1 → rd_vld for 16 consecutive cycles, rd_cut 0..15, rd_last on cut 15. Next cycle: slot_free_vld=1 with id 0, and done=1.
2. cmd_iter_nb=0 → accepted, done pulses the next cycle, rd_vld never rises, slot_ptr unchanged.
3. cmd_iter_nb=6, SLOT_NB=4, loader refills each slot after slot_free → slots read in order 0,1,2,3,0,1; six slot_free pulses; done after the 6th.
4. Start a command with slot 0 at 15/16 cuts → block waits in WAIT_FULL with rd_vld=0. Deliver cut 7 at cycle N → rd_vld=1 at N+2.
5. Random rd_rdy backpressure (50%) → rd_slot and rd_cut stable while stalled; exactly 16 accepted beats per column; no beat lost or duplicated.
6. Load the same slot/cut twice → err_double_load=1 and stays set until err_clr. Separately, assert a_rst mid-READ → all outputs 0, all masks cleared, and a following command waits for fresh loads.
